// File: rtl/zpu_mem_responder_if.sv
// Memory bus between zpu_core (master) and the memory/IO responder (slave).
// A request is held by the master until the slave pulses mem_done.
interface zpu_mem_responder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data_write;
    logic                  mem_done;
    logic [31:0]           mem_data_read;

    modport master (
        output mem_read, mem_write, mem_addr, mem_data_write,
        input  mem_done, mem_data_read
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_data_write,
        output mem_done, mem_data_read
    );
endinterface

// File: rtl/zpu_mem_responder.sv
// Responder end of the zpu_core memory bus: block RAM in the lower half of the
// address space, LED/CYCLES/SCRATCH/FAULTS registers in the upper half.
module zpu_mem_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    zpu_mem_responder_if.slave  bus,
    output logic [4:0]          led
);
    localparam int IDX_W     = ADDR_WIDTH - 3;
    localparam int RAM_WORDS = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_RDWAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_rd;
    logic        r_wr;
    logic        r_done;
    logic [31:0] r_data_read;
    logic [31:0] r_hold;
    logic [4:0]  r_led;
    logic [31:0] r_cycles;
    logic [31:0] r_scratch;
    logic [15:0] r_faults;
    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_ram_q;

    logic             w_io;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_widx;
    logic             w_fault;
    logic             w_ram_we;
    logic [31:0]      w_io_rdata;
    logic             w_unused_addr;

    assign w_io          = bus.mem_addr[ADDR_WIDTH-1];
    assign w_off         = bus.mem_addr[3:2];
    assign w_widx        = bus.mem_addr[ADDR_WIDTH-2:2];
    assign w_fault       = r_rd && r_wr;
    assign w_unused_addr = ^bus.mem_addr[1:0];

    // Gated by the async-reset state register, so a reset before the commit
    // edge drops the write even though the RAM itself is never reset.
    assign w_ram_we = (r_state == S_ACCEPT) && r_wr && !r_rd && !w_io;

    always_comb begin
        w_io_rdata = 32'd0;
        case (w_off)
            2'd0:    w_io_rdata = {27'd0, r_led};
            2'd1:    w_io_rdata = r_cycles;
            2'd2:    w_io_rdata = r_scratch;
            default: w_io_rdata = {16'd0, r_faults};
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_widx] <= bus.mem_data_write;
        end
        r_ram_q <= r_ram[w_widx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_done      <= 1'b0;
            r_data_read <= 32'd0;
            r_hold      <= 32'd0;
            r_led       <= 5'd0;
            r_cycles    <= 32'd0;
            r_scratch   <= 32'd0;
            r_faults    <= 16'd0;
        end else begin
            r_done   <= 1'b0;
            r_cycles <= r_cycles + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        r_rd    <= bus.mem_read;
                        r_wr    <= bus.mem_write;
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_fault) begin
                        r_hold <= 32'd0;
                        if (r_faults != 16'hFFFF) begin
                            r_faults <= r_faults + 16'd1;
                        end
                        r_state <= S_RESP;
                    end else if (w_io) begin
                        if (r_wr) begin
                            case (w_off)
                                2'd0:    r_led     <= bus.mem_data_write[4:0];
                                2'd1:    r_cycles  <= 32'd0;
                                2'd2:    r_scratch <= bus.mem_data_write;
                                default: r_faults  <= 16'd0;
                            endcase
                        end else begin
                            r_hold <= w_io_rdata;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_state <= r_rd ? S_RDWAIT : S_RESP;
                    end
                end
                S_RDWAIT: begin
                    r_hold  <= r_ram_q;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    // Reads and faults publish their result; writes keep the old one.
                    r_done <= 1'b1;
                    if (r_rd) begin
                        r_data_read <= r_hold;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_done      = r_done;
    assign bus.mem_data_read = r_data_read;
    assign led               = r_led;
endmodule

// File: tb/tb_zpu_mem_responder.sv
// Directed bench for zpu_mem_responder with a transaction-level memory/IO model
// and a per-cycle output comparator.
module tb_zpu_mem_responder;
    logic       clk;
    logic       reset;
    logic [4:0] led;

    zpu_mem_responder_if #(.ADDR_WIDTH(10)) bus ();

    zpu_mem_responder #(.ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;

    // Model state: what the responder must hold, derived from the register map.
    logic [31:0] m_ram [128];
    logic [4:0]  m_led = 5'd0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_scr = 32'd0;
    logic [15:0] m_flt = 16'd0;
    logic [31:0] exp_rd = 32'd0;
    int          exp_done_at = -1;
    int          clr_at = -1;
    logic [31:0] got;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ecnt);
        end
    endtask

    // Cycle index and the free-running counter as seen from outside.
    always @(posedge clk) begin
        ecnt++;
        if (reset) m_cyc = 32'd0;
        else if (ecnt == clr_at) m_cyc = 32'd0;
        else m_cyc = m_cyc + 32'd1;
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("done", {31'd0, bus.mem_done}, {31'd0, (ecnt == exp_done_at)});
            chk("rdata", bus.mem_data_read, exp_rd);
            chk("led", {27'd0, led}, {27'd0, m_led});
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [9:0] addr,
                       input logic [31:0] data, output logic [31:0] rdv);
        int          e0;
        int          lat;
        logic [31:0] nv;
        bit          seen;
        @(negedge clk);
        bus.mem_read       = rd;
        bus.mem_write      = wr;
        bus.mem_addr       = addr;
        bus.mem_data_write = data;
        e0 = ecnt + 1;
        @(negedge clk);
        nv  = 32'd0;
        lat = 2;
        if (rd && wr) begin
            if (m_flt != 16'hFFFF) m_flt = m_flt + 16'd1;
        end else if (addr[9]) begin
            if (rd) begin
                case (addr[3:2])
                    2'd0:    nv = {27'd0, m_led};
                    2'd1:    nv = m_cyc;
                    2'd2:    nv = m_scr;
                    default: nv = {16'd0, m_flt};
                endcase
            end else begin
                case (addr[3:2])
                    2'd0:    m_led = data[4:0];
                    2'd1:    clr_at = e0 + 1;
                    2'd2:    m_scr = data;
                    default: m_flt = 16'd0;
                endcase
            end
        end else if (rd) begin
            nv  = m_ram[addr[8:2]];
            lat = 3;
        end else begin
            m_ram[addr[8:2]] = data;
        end
        exp_done_at = e0 + lat;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rd && ecnt == exp_done_at - 1) exp_rd = nv;
            if (bus.mem_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rdv = bus.mem_data_read;
        if (!seen) chk("timeout", 32'd0, 32'd1);
        else chk("latency", ecnt - e0, lat);
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr = 10'd0;
        bus.mem_data_write = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // RAM write/read, neighbouring word keeps its own contents
        req(0, 1, 10'h008, 32'h11112222, got);
        req(0, 1, 10'h004, 32'hDEADBEEF, got);
        req(1, 0, 10'h004, 32'h0, got);
        chk("ram_rd_4", got, 32'hDEADBEEF);
        req(1, 0, 10'h008, 32'h0, got);
        chk("ram_rd_8", got, 32'h11112222);

        // LED register
        req(0, 1, 10'h200, 32'h0000001F, got);
        chk("led_1f", {27'd0, led}, 32'h1F);
        req(1, 0, 10'h200, 32'h0, got);
        chk("led_rd", got, 32'h0000001F);
        req(0, 1, 10'h200, 32'h00000035, got);
        chk("led_35", {27'd0, led}, 32'h15);

        // CYCLES: clear then read back-to-back, then after a gap
        req(0, 1, 10'h204, 32'h12345678, got);
        req(1, 0, 10'h204, 32'h0, got);
        chk("cyc_b2b", got, 32'd3);
        repeat (7) @(negedge clk);
        req(1, 0, 10'h204, 32'h0, got);

        // SCRATCH through an aliased IO address
        req(0, 1, 10'h208, 32'hA5A50001, got);
        req(1, 0, 10'h3F8, 32'h0, got);
        chk("scr_alias", got, 32'hA5A50001);

        // CYCLES wrap
        @(negedge clk);
        force dut.r_cycles = 32'hFFFFFFFE;
        @(negedge clk);
        release dut.r_cycles;
        m_cyc = 32'hFFFFFFFE;
        req(1, 0, 10'h204, 32'h0, got);
        chk("cyc_wrap", got, 32'd0);

        // Fault handling and FAULTS saturation
        req(0, 1, 10'h010, 32'hCAFE0010, got);
        req(1, 1, 10'h010, 32'h12345678, got);
        chk("fault_rd", got, 32'd0);
        req(1, 0, 10'h010, 32'h0, got);
        chk("fault_nowr", got, 32'hCAFE0010);
        req(1, 0, 10'h20C, 32'h0, got);
        chk("faults_1", got, 32'd1);
        @(negedge clk);
        force dut.r_faults = 16'hFFFE;
        @(negedge clk);
        release dut.r_faults;
        m_flt = 16'hFFFE;
        req(1, 1, 10'h010, 32'h12345678, got);
        req(1, 1, 10'h010, 32'h12345678, got);
        req(1, 0, 10'h20C, 32'h0, got);
        chk("faults_sat", got, 32'h0000FFFF);
        req(0, 1, 10'h20C, 32'h0, got);
        req(1, 0, 10'h20C, 32'h0, got);
        chk("faults_clr", got, 32'd0);

        // Reset during a RAM read
        req(1, 0, 10'h004, 32'h0, got);
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_addr = 10'h004;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_led = 5'd0; m_scr = 32'd0; m_flt = 16'd0; m_cyc = 32'd0;
        exp_rd = 32'd0; exp_done_at = -1; clr_at = -1;
        #1;
        chk("rst_done", {31'd0, bus.mem_done}, 32'd0);
        chk("rst_rdata", bus.mem_data_read, 32'd0);
        chk("rst_led", {27'd0, led}, 32'd0);
        bus.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        req(1, 0, 10'h004, 32'h0, got);
        chk("post_rst_rd", got, 32'hDEADBEEF);
        req(1, 0, 10'h200, 32'h0, got);
        chk("post_rst_led", got, 32'd0);
        req(1, 0, 10'h204, 32'h0, got);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
